// File: rtl/dpram_be_if.sv
// Bus bundle for the byte-enabled dual-port RAM: both access ports plus status outputs.
// Parameters must match the dpram_be instance the bundle is connected to.
interface dpram_be_if #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter int BYTE_W = 8
);
    localparam int NB = WIDTH / BYTE_W;
    localparam int AW = $clog2(DEPTH);

    logic             init_busy;
    logic             en_a;
    logic [NB-1:0]    we_a;
    logic [AW-1:0]    addr_a;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] dout_a;
    logic             rvalid_a;
    logic             en_b;
    logic [NB-1:0]    we_b;
    logic [AW-1:0]    addr_b;
    logic [WIDTH-1:0] din_b;
    logic [WIDTH-1:0] dout_b;
    logic             rvalid_b;
    logic             collision;

    modport master (
        input  init_busy, dout_a, rvalid_a, dout_b, rvalid_b, collision,
        output en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b
    );

    modport slave (
        output init_busy, dout_a, rvalid_a, dout_b, rvalid_b, collision,
        input  en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b
    );
endinterface

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, post-reset clear sweep, read-valid strobes and collision flag.
// Define DPRAM_OUTREG_EN to add a second output register stage (2-cycle read latency).
module dpram_be #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 32,
    parameter int BYTE_W   = 8,
    parameter int RDW_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    dpram_be_if.slave  bus
);
    localparam int NB = WIDTH / BYTE_W;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             clear_we;
    logic             run;
    logic             range_a, range_b;
    logic             acc_a, acc_b, wr_a, wr_b;
    logic             same_addr, both;
    logic [WIDTH-1:0] old_a, old_b, final_a, final_b, rd_a, rd_b;
    logic [WIDTH-1:0] dout_a_q, dout_b_q;
    logic             rvalid_a_q, rvalid_b_q, collision_q;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sweep zeroes one word per cycle, then RUN until the next reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_we = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_we = 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: ;
        endcase
    end

    assign run = (state_q == RUN);

    generate
        if (DEPTH == (1 << AW)) begin : g_pow2
            assign range_a = 1'b1;
            assign range_b = 1'b1;
        end else begin : g_npow2
            assign range_a = ({1'b0, bus.addr_a} < (AW + 1)'(DEPTH));
            assign range_b = ({1'b0, bus.addr_b} < (AW + 1)'(DEPTH));
        end
    endgenerate

    assign acc_a     = run & bus.en_a;
    assign acc_b     = run & bus.en_b;
    assign wr_a      = acc_a & range_a;
    assign wr_b      = acc_b & range_b;
    assign same_addr = (bus.addr_a == bus.addr_b);
    assign both      = acc_a & acc_b & same_addr;

    // final_x is the word the addressed location will hold after this edge, with port A
    // taking priority on lanes both ports write.
    always_comb begin
        old_a   = range_a ? mem[bus.addr_a] : '0;
        old_b   = range_b ? mem[bus.addr_b] : '0;
        final_a = old_a;
        final_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (bus.we_a[i])
                final_a[i*BYTE_W +: BYTE_W] = bus.din_a[i*BYTE_W +: BYTE_W];
            else if (both && bus.we_b[i])
                final_a[i*BYTE_W +: BYTE_W] = bus.din_b[i*BYTE_W +: BYTE_W];
            if (both && bus.we_a[i])
                final_b[i*BYTE_W +: BYTE_W] = bus.din_a[i*BYTE_W +: BYTE_W];
            else if (bus.we_b[i])
                final_b[i*BYTE_W +: BYTE_W] = bus.din_b[i*BYTE_W +: BYTE_W];
        end
        if (!range_a) final_a = '0;
        if (!range_b) final_b = '0;
        rd_a = ((|bus.we_a) && (RDW_MODE != 0)) ? final_a : old_a;
        rd_b = ((|bus.we_b) && (RDW_MODE != 0)) ? final_b : old_b;
    end

    // Port A lanes are written last so they override port B on a shared address.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && bus.we_b[i])
                    mem[bus.addr_b][i*BYTE_W +: BYTE_W] <= bus.din_b[i*BYTE_W +: BYTE_W];
                if (wr_a && bus.we_a[i])
                    mem[bus.addr_a][i*BYTE_W +: BYTE_W] <= bus.din_a[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            if (acc_a) dout_a_q <= rd_a;
            if (acc_b) dout_b_q <= rd_b;
            rvalid_a_q  <= acc_a;
            rvalid_b_q  <= acc_b;
            collision_q <= both & ((|bus.we_a) | (|bus.we_b));
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic [WIDTH-1:0] dout_a_q2, dout_b_q2;
    logic             rvalid_a_q2, rvalid_b_q2, collision_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a_q2    <= '0;
            dout_b_q2    <= '0;
            rvalid_a_q2  <= 1'b0;
            rvalid_b_q2  <= 1'b0;
            collision_q2 <= 1'b0;
        end else begin
            dout_a_q2    <= dout_a_q;
            dout_b_q2    <= dout_b_q;
            rvalid_a_q2  <= rvalid_a_q;
            rvalid_b_q2  <= rvalid_b_q;
            collision_q2 <= collision_q;
        end
    end

    assign bus.dout_a    = dout_a_q2;
    assign bus.dout_b    = dout_b_q2;
    assign bus.rvalid_a  = rvalid_a_q2;
    assign bus.rvalid_b  = rvalid_b_q2;
    assign bus.collision = collision_q2;
`else
    assign bus.dout_a    = dout_a_q;
    assign bus.dout_b    = dout_b_q;
    assign bus.rvalid_a  = rvalid_a_q;
    assign bus.rvalid_b  = rvalid_b_q;
    assign bus.collision = collision_q;
`endif

    assign bus.init_busy = (state_q == CLEAR);
endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be: three instances (read-first, write-first, DEPTH=12) share one stimulus.
// Expected latency follows DPRAM_OUTREG_EN.
module tb_dpram_be;
`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   busy_main, busy_d12, rv_seen;

    dpram_be_if #(.DEPTH(16), .WIDTH(32), .BYTE_W(8)) bus0 ();
    dpram_be_if #(.DEPTH(16), .WIDTH(32), .BYTE_W(8)) bus1 ();
    dpram_be_if #(.DEPTH(12), .WIDTH(32), .BYTE_W(8)) bus2 ();

    dpram_be #(.DEPTH(16), .WIDTH(32), .BYTE_W(8), .RDW_MODE(0)) u_rf  (.clk(clk), .rst(rst), .bus(bus0));
    dpram_be #(.DEPTH(16), .WIDTH(32), .BYTE_W(8), .RDW_MODE(1)) u_wf  (.clk(clk), .rst(rst), .bus(bus1));
    dpram_be #(.DEPTH(12), .WIDTH(32), .BYTE_W(8), .RDW_MODE(0)) u_d12 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus1.en_a = bus0.en_a;  assign bus2.en_a = bus0.en_a;
    assign bus1.we_a = bus0.we_a;  assign bus2.we_a = bus0.we_a;
    assign bus1.addr_a = bus0.addr_a;  assign bus2.addr_a = bus0.addr_a;
    assign bus1.din_a = bus0.din_a;  assign bus2.din_a = bus0.din_a;
    assign bus1.en_b = bus0.en_b;  assign bus2.en_b = bus0.en_b;
    assign bus1.we_b = bus0.we_b;  assign bus2.we_b = bus0.we_b;
    assign bus1.addr_b = bus0.addr_b;  assign bus2.addr_b = bus0.addr_b;
    assign bus1.din_b = bus0.din_b;  assign bus2.din_b = bus0.din_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access cycle on both ports, then wait until its results are visible.
    task automatic applyStimulus(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                                 input logic [31:0] da, input logic eb, input logic [3:0] wb,
                                 input logic [3:0] ab, input logic [31:0] db);
        @(negedge clk);
        bus0.en_a = ea; bus0.we_a = wa; bus0.addr_a = aa; bus0.din_a = da;
        bus0.en_b = eb; bus0.we_b = wb; bus0.addr_b = ab; bus0.din_b = db;
        @(posedge clk);
        #1;
        bus0.en_a = 1'b0; bus0.we_a = '0;
        bus0.en_b = 1'b0; bus0.we_b = '0;
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_clear(output int bm, output int bd, output int rv);
        @(negedge clk);
        rst = 1'b0;
        bm = 0; bd = 0; rv = 0;
        for (int i = 0; i < 64; i++) begin
            if (!bus0.init_busy) break;
            bm++;
            if (bus2.init_busy) bd++;
            if (bus0.rvalid_a) rv++;
            @(negedge clk);
        end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1;
        bus0.en_a = 0; bus0.we_a = '0; bus0.addr_a = '0; bus0.din_a = '0;
        bus0.en_b = 0; bus0.we_b = '0; bus0.addr_b = '0; bus0.din_b = '0;
        #3;
        checkOutput("rst_dout_a", bus0.dout_a, 32'h0);
        checkOutput("rst_rvalid_a", {31'b0, bus0.rvalid_a}, 32'h0);
        checkOutput("rst_collision", {31'b0, bus0.collision}, 32'h0);
        checkOutput("rst_init_busy", {31'b0, bus0.init_busy}, 32'h1);

        // Sweep with port A held enabled: it must be ignored while busy.
        bus0.en_a = 1'b1;
        run_clear(busy_main, busy_d12, rv_seen);
        bus0.en_a = 1'b0;
        checkOutput("busy_cycles_16", busy_main, 16);
        checkOutput("busy_cycles_12", busy_d12, 12);
        checkOutput("rvalid_during_clear", rv_seen, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 4'h0, 4'(i), 32'h0, 0, 4'h0, 4'h0, 32'h0);
            checkOutput($sformatf("clear_rd_%0d", i), bus0.dout_a, 32'h0);
        end

        // Byte-lane merge
        applyStimulus(1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 4'h0, 4'h0, 32'h0);
        checkOutput("wr_full_old_rf", bus0.dout_a, 32'h0);
        checkOutput("wr_full_new_wf", bus1.dout_a, 32'hDEADBEEF);
        applyStimulus(1, 4'h1, 4'd3, 32'h000000AA, 0, 4'h0, 4'h0, 32'h0);
        checkOutput("wr_lane0_old_rf", bus0.dout_a, 32'hDEADBEEF);
        checkOutput("wr_lane0_new_wf", bus1.dout_a, 32'hDEADBEAA);
        applyStimulus(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 4'd3, 32'h0);
        checkOutput("rd_b_merged", bus0.dout_b, 32'hDEADBEAA);
        checkOutput("rd_b_rvalid", {31'b0, bus0.rvalid_b}, 32'h1);
        applyStimulus(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0);
        checkOutput("idle_rvalid_b", {31'b0, bus0.rvalid_b}, 32'h0);
        checkOutput("idle_dout_b_hold", bus0.dout_b, 32'hDEADBEAA);

        // Write-write collision, A wins on shared lanes
        applyStimulus(1, 4'h3, 4'd5, 32'h11111111, 1, 4'hF, 4'd5, 32'h22222222);
        checkOutput("ww_collision", {31'b0, bus0.collision}, 32'h1);
        checkOutput("ww_collision_d12", {31'b0, bus2.collision}, 32'h1);
        applyStimulus(1, 4'h0, 4'd5, 32'h0, 0, 4'h0, 4'h0, 32'h0);
        checkOutput("ww_result", bus0.dout_a, 32'h22221111);
        checkOutput("ww_collision_clear", {31'b0, bus0.collision}, 32'h0);

        // Read vs write on the same address
        applyStimulus(1, 4'hF, 4'd7, 32'h1, 0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1, 4'hF, 4'd7, 32'h2, 1, 4'h0, 4'd7, 32'h0);
        checkOutput("rw_dout_b_rf", bus0.dout_b, 32'h1);
        checkOutput("rw_dout_b_wf", bus1.dout_b, 32'h1);
        checkOutput("rw_collision", {31'b0, bus0.collision}, 32'h1);
        checkOutput("rw_dout_a_rf", bus0.dout_a, 32'h1);
        checkOutput("rw_dout_a_wf", bus1.dout_a, 32'h2);

        // Both reading the same address is not a collision
        applyStimulus(1, 4'h0, 4'd7, 32'h0, 1, 4'h0, 4'd7, 32'h0);
        checkOutput("rr_no_collision", {31'b0, bus0.collision}, 32'h0);
        checkOutput("rr_dout_b", bus0.dout_b, 32'h2);

        // Out-of-range address on the 12-word instance
        applyStimulus(1, 4'hF, 4'd13, 32'hFFFFFFFF, 0, 4'h0, 4'h0, 32'h0);
        checkOutput("oor_wr_dout_d12", bus2.dout_a, 32'h0);
        checkOutput("oor_wr_rvalid_d12", {31'b0, bus2.rvalid_a}, 32'h1);
        applyStimulus(1, 4'h0, 4'd13, 32'h0, 1, 4'h0, 4'd3, 32'h0);
        checkOutput("oor_rd_d12", bus2.dout_a, 32'h0);
        checkOutput("oor_rd_rvalid_d12", {31'b0, bus2.rvalid_a}, 32'h1);
        checkOutput("oor_rd_main", bus0.dout_a, 32'hFFFFFFFF);
        checkOutput("d12_addr3", bus2.dout_b, 32'hDEADBEAA);
        applyStimulus(1, 4'h0, 4'd5, 32'h0, 1, 4'h0, 4'd7, 32'h0);
        checkOutput("d12_addr5", bus2.dout_a, 32'h22221111);
        checkOutput("d12_addr7", bus2.dout_b, 32'h2);
        applyStimulus(1, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd11, 32'h0);
        checkOutput("d12_addr0", bus2.dout_a, 32'h0);
        checkOutput("d12_addr11", bus2.dout_b, 32'h0);

        // Reset during the sweep restarts it from word 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        run_clear(busy_main, busy_d12, rv_seen);
        checkOutput("restart_busy_16", busy_main, 16);
        checkOutput("restart_busy_12", busy_d12, 12);

        // Exact read latency
        @(negedge clk);
        bus0.en_a = 1'b1; bus0.addr_a = 4'd13;
        @(posedge clk); #1;
        bus0.en_a = 1'b0;
        checkOutput("lat_edge1_rvalid", {31'b0, bus0.rvalid_a}, (LAT == 1) ? 32'h1 : 32'h0);
        @(posedge clk); #1;
        checkOutput("lat_edge2_rvalid", {31'b0, bus0.rvalid_a}, (LAT == 2) ? 32'h1 : 32'h0);
        checkOutput("lat_dout_cleared", bus0.dout_a, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
